alu_arbiter: RTL and testbench

Shares one combinational ALU between two requesters, for example the execute stage and an address/branch helper, or two cores in the multicore build. Each cycle it grants the ALU to at most one requester and drives that requester's op/operands to the ALU. It registers the result and flags and returns them to the winner one cycle later. Arbitration is round-robin, with an optional bounded lock so a requester can run back-to-back dependent operations without interruption.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a bounded ownership lock and a registered result/flag return path.
package alu_arbiter_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } aluop_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  req,
  input  logic [1:0]  lock,
  input  aluop_t      op0,
  input  aluop_t      op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rout,
  output logic        rnf,
  output logic        rzf,
  output logic        rvf,
  output aluop_t      alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_nf,
  input  logic        alu_zf,
  input  logic        alu_vf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_LOCK_W = 4'(MAX_LOCK);

  state_t      state_reg, state_next;
  logic [3:0]  lcnt_reg, lcnt_next;
  logic        keep0, keep1;

  // The owner may hold the ALU against a waiting peer only while under budget.
  assign keep0 = (state_reg == OWN0) && lock[0] && (lcnt_reg < MAX_LOCK_W);
  assign keep1 = (state_reg == OWN1) && lock[1] && (lcnt_reg < MAX_LOCK_W);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      lcnt_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      lcnt_reg  <= lcnt_next;
    end
  end

  always_comb begin
    gnt        = 2'b00;
    state_next = state_reg;
    lcnt_next  = lcnt_reg;

    // No operation is issued while reset is asserted.
    if (nRST) begin
      case (req)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
          case (state_reg)
            OWN0:    gnt = keep0 ? 2'b01 : 2'b10;
            OWN1:    gnt = keep1 ? 2'b10 : 2'b01;
            default: gnt = 2'b01;
          endcase
        end
        default: gnt = 2'b00;
      endcase
    end

    if (gnt[0]) begin
      state_next = OWN0;
      if ((state_reg == OWN0) && lock[0]) begin
        // An unchallenged lock holds the count rather than consuming budget.
        if (req[1] && (lcnt_reg < MAX_LOCK_W))
          lcnt_next = lcnt_reg + 4'd1;
      end else begin
        lcnt_next = 4'd0;
      end
    end else if (gnt[1]) begin
      state_next = OWN1;
      if ((state_reg == OWN1) && lock[1]) begin
        if (req[0] && (lcnt_reg < MAX_LOCK_W))
          lcnt_next = lcnt_reg + 4'd1;
      end else begin
        lcnt_next = 4'd0;
      end
    end
  end

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = 32'h0;
    alu_b  = 32'h0;
    if (gnt[0]) begin
      alu_op = op0;
      alu_a  = a0;
      alu_b  = b0;
    end else if (gnt[1]) begin
      alu_op = op1;
      alu_a  = a1;
      alu_b  = b1;
    end
  end

  // Result and flags are held across idle cycles; only rvalid pulses.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rvalid <= 2'b00;
      rout   <= 32'h0;
      rnf    <= 1'b0;
      rzf    <= 1'b0;
      rvf    <= 1'b0;
    end else begin
      rvalid <= gnt;
      if (gnt != 2'b00) begin
        rout <= alu_out;
        rnf  <= alu_nf;
        rzf  <= alu_zf;
        rvf  <= alu_vf;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU stub closes the loop and each
// scenario task checks grants and returned results against hand-worked values.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        CLK;
  logic        nRST;
  logic [1:0]  req;
  logic [1:0]  lock;
  aluop_t      op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rout;
  logic        rnf, rzf, rvf;
  aluop_t      alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic        alu_nf, alu_zf, alu_vf;

  int tests;
  int fails;

  alu_arbiter #(.MAX_LOCK(4)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .lock(lock),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .rvalid(rvalid), .rout(rout), .rnf(rnf), .rzf(rzf), .rvf(rvf),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_nf(alu_nf), .alu_zf(alu_zf), .alu_vf(alu_vf)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Shared ALU stub.
  always_comb begin
    alu_out = 32'h0;
    alu_vf  = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_out = alu_a + alu_b;
        alu_vf  = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      ALU_SUB: begin
        alu_out = alu_a - alu_b;
        alu_vf  = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = alu_a;
    endcase
    alu_nf = alu_out[31];
    alu_zf = (alu_out == 32'h0);
  end

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    req  = 2'b00;
    lock = 2'b00;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    req  = 2'b11;
    lock = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      #1;
      tests++;
      if (gnt !== 2'b00) begin
        fails++;
        $display("FAIL reset_gnt: got %b expected 00", gnt);
      end
    end
    tests++;
    if (rvalid !== 2'b00 || rout !== 32'h0 || {rnf, rzf, rvf} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: rvalid=%b rout=%h flags=%b expected 00/0/000",
               rvalid, rout, {rnf, rzf, rvf});
    end
    $display("[TB] reset: gnt=%b rvalid=%b rout=%h", gnt, rvalid, rout);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    tests++;
    if (gnt !== 2'b01) begin
      fails++;
      $display("FAIL reset_first_grant: got %b expected 01", gnt);
    end
    $display("[TB] reset release: gnt=%b", gnt);
    @(negedge CLK);
    req = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge CLK);
    req = 2'b01; op0 = ALU_ADD; a0 = 32'd7; b0 = 32'd5;
    #1;
    tests++;
    if (gnt !== 2'b01 || alu_a !== 32'd7 || alu_b !== 32'd5) begin
      fails++;
      $display("FAIL single_gnt: gnt=%b alu_a=%0d alu_b=%0d expected 01/7/5", gnt, alu_a, alu_b);
    end
    @(negedge CLK);
    req = 2'b00;
    #1;
    tests++;
    if (rvalid !== 2'b01 || rout !== 32'd12 || rzf !== 1'b0) begin
      fails++;
      $display("FAIL single_result: rvalid=%b rout=%0d rzf=%b expected 01/12/0", rvalid, rout, rzf);
    end
    $display("[TB] single: rvalid=%b rout=%0d rzf=%b", rvalid, rout, rzf);
    @(negedge CLK);
    #1;
    tests++;
    if (rvalid !== 2'b00 || rout !== 32'd12 || gnt !== 2'b00 || alu_op !== ALU_ADD || alu_a !== 32'h0) begin
      fails++;
      $display("FAIL single_idle_hold: rvalid=%b rout=%0d gnt=%b alu_a=%h expected 00/12/00/0",
               rvalid, rout, gnt, alu_a);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt [4];
    logic [31:0] res;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    do_reset();
    @(negedge CLK);
    op0 = ALU_SUB; a0 = 32'd3; b0 = 32'd3;
    op1 = ALU_OR;  a1 = 32'd1; b1 = 32'd2;
    lock = 2'b00;
    req  = 2'b11;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req = 2'b00;
      #1;
      if (k < 4) begin
        tests++;
        if (gnt !== exp_gnt[k]) begin
          fails++;
          $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt[k]);
        end
      end
      if (k > 0) begin
        res = (exp_gnt[k-1] == 2'b01) ? 32'd0 : 32'd3;
        tests++;
        if (rvalid !== exp_gnt[k-1] || rout !== res || rzf !== (res == 32'd0)) begin
          fails++;
          $display("FAIL rr_result[%0d]: rvalid=%b rout=%0d rzf=%b expected %b/%0d/%b",
                   k, rvalid, rout, rzf, exp_gnt[k-1], res, (res == 32'd0));
        end
      end
      $display("[TB] rr cycle %0d: gnt=%b rvalid=%b rout=%0d", k, gnt, rvalid, rout);
      @(negedge CLK);
    end
  endtask

  task automatic test_lock_bound();
    logic [1:0] exp_gnt [6];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01;
    exp_gnt[3] = 2'b01; exp_gnt[4] = 2'b10; exp_gnt[5] = 2'b01;
    do_reset();
    @(negedge CLK);
    op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd1;
    op1 = ALU_ADD; a1 = 32'd2; b1 = 32'd2;
    req = 2'b01; lock = 2'b01;
    #1;
    tests++;
    if (gnt !== 2'b01) begin
      fails++;
      $display("FAIL lock_own: got %b expected 01", gnt);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      req = 2'b11; lock = 2'b01;
      #1;
      tests++;
      if (gnt !== exp_gnt[k]) begin
        fails++;
        $display("FAIL lock_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt[k]);
      end
      $display("[TB] lock cycle %0d: gnt=%b", k, gnt);
    end
    @(negedge CLK);
    req = 2'b00; lock = 2'b00;
  endtask

  task automatic test_overflow();
    do_reset();
    @(negedge CLK);
    op1 = ALU_ADD; a1 = 32'h7FFF_FFFF; b1 = 32'd1;
    req = 2'b10;
    #1;
    tests++;
    if (gnt !== 2'b10) begin
      fails++;
      $display("FAIL ovf_gnt: got %b expected 10", gnt);
    end
    @(negedge CLK);
    req = 2'b00;
    #1;
    tests++;
    if (rvalid !== 2'b10 || rout !== 32'h8000_0000 || rvf !== 1'b1 || rnf !== 1'b1 || rzf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_result: rvalid=%b rout=%h nzv=%b%b%b expected 10/80000000/101",
               rvalid, rout, rnf, rzf, rvf);
    end
    $display("[TB] overflow: rout=%h n=%b v=%b", rout, rnf, rvf);
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge CLK);
    op1 = ALU_XOR; a1 = 32'hF0; b1 = 32'h0F;
    req = 2'b10; lock = 2'b10;
    #1;
    tests++;
    if (gnt !== 2'b10) begin
      fails++;
      $display("FAIL async_gnt: got %b expected 10", gnt);
    end
    @(posedge CLK);
    #1;
    req = 2'b00;
    tests++;
    if (rvalid !== 2'b10 || rout !== 32'hFF) begin
      fails++;
      $display("FAIL async_pre: rvalid=%b rout=%h expected 10/ff", rvalid, rout);
    end
    nRST = 1'b0;
    #1;
    tests++;
    if (rvalid !== 2'b00 || gnt !== 2'b00) begin
      fails++;
      $display("FAIL async_clear: rvalid=%b gnt=%b expected 00/00", rvalid, gnt);
    end
    $display("[TB] async reset: rvalid=%b", rvalid);
    @(negedge CLK);
    req = 2'b11; lock = 2'b10;
    nRST = 1'b1;
    #1;
    tests++;
    if (gnt !== 2'b01) begin
      fails++;
      $display("FAIL async_release_gnt: got %b expected 01", gnt);
    end
    $display("[TB] async release: gnt=%b", gnt);
    @(negedge CLK);
    req = 2'b00; lock = 2'b00;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nRST  = 1'b0;
    req   = 2'b00;
    lock  = 2'b00;
    op0   = ALU_ADD; op1 = ALU_ADD;
    a0 = 32'h0; b0 = 32'h0; a1 = 32'h0; b1 = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock_bound();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
